// File: rtl/param_stack_if.sv
// Handshake/data bundle between a LIFO stack and its user.
// The master drives the commands and the slave (the stack) drives the status.
interface param_stack_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, din,
        input  dout, dout_valid, top, count, empty, full, almost_full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, din,
        output dout, dout_valid, top, count, empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO stack with simultaneous push+pop, registered pop data,
// combinational peek, occupancy flags and sticky overflow/underflow errors.
module param_stack #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic          clk,
    input  logic          rstn,
    param_stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    count_m1_s;
    logic [WIDTH-1:0] dout_nxt_s;
    logic             dout_valid_nxt_s;
    logic             overflow_nxt_s;
    logic             underflow_nxt_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_addr_s;
    logic [AW-1:0]    top_addr_s;
    logic             empty_s;
    logic             full_s;

    // Occupancy decodes; the top index is only meaningful when not empty.
    assign empty_s    = (count_r == ZERO_C);
    assign full_s     = (count_r == DEPTH_C);
    assign count_m1_s = count_r - ONE_C;
    assign top_addr_s = count_m1_s[AW-1:0];

    // Per-cycle command decode in priority order: clear, push, pop, push+pop, hold.
    always_comb begin
        count_nxt_s      = count_r;
        dout_nxt_s       = dout_r;
        dout_valid_nxt_s = 1'b0;
        overflow_nxt_s   = overflow_r;
        underflow_nxt_s  = underflow_r;
        mem_we_s         = 1'b0;
        mem_addr_s       = top_addr_s;
        if (bus.clear) begin
            count_nxt_s     = ZERO_C;
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else if (bus.push && !bus.pop) begin
            if (!full_s) begin
                mem_we_s    = 1'b1;
                mem_addr_s  = count_r[AW-1:0];
                count_nxt_s = count_r + ONE_C;
            end else begin
                overflow_nxt_s = 1'b1;
            end
        end else if (bus.pop && !bus.push) begin
            if (!empty_s) begin
                dout_nxt_s       = mem_r[top_addr_s];
                dout_valid_nxt_s = 1'b1;
                count_nxt_s      = count_m1_s;
            end else begin
                underflow_nxt_s = 1'b1;
            end
        end else if (bus.push && bus.pop) begin
            // Replace the top in place; on an empty stack the word passes straight through.
            if (!empty_s) begin
                dout_nxt_s = mem_r[top_addr_s];
                mem_we_s   = 1'b1;
            end else begin
                dout_nxt_s = bus.din;
            end
            dout_valid_nxt_s = 1'b1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r      <= ZERO_C;
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            overflow_r   <= overflow_nxt_s;
            underflow_r  <= underflow_nxt_s;
        end
    end

    // Storage array; left unreset since entries above count are never observed.
    always_ff @(posedge clk) begin
        if (mem_we_s && rstn) begin
            mem_r[mem_addr_s] <= bus.din;
        end
    end

    assign bus.count       = count_r;
    assign bus.dout        = dout_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
    assign bus.empty       = empty_s;
    assign bus.full        = full_s;
    assign bus.almost_full = (count_r >= AF_C);
    assign bus.top         = empty_s ? {WIDTH{1'b0}} : mem_r[top_addr_s];
endmodule

// File: tb/tb_param_stack.sv
// Directed, table-driven bench for param_stack (DEPTH=16, WIDTH=8, AF_THRESH=14).
module tb_param_stack;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    param_stack_if #(.DEPTH(16), .WIDTH(8)) bus ();

    param_stack #(.DEPTH(16), .WIDTH(8), .AF_THRESH(14)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clear;
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [4:0] count;
        logic [7:0] top;
        logic [7:0] dout;
        logic       dv;
        logic       empty;
        logic       full;
        logic       af;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] cnt, input logic [7:0] tp,
                           input logic [7:0] dout, input logic dv, input logic emp,
                           input logic full, input logic af, input logic ovf, input logic udf);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".top"}, 32'(bus.top), 32'(tp));
        chk({tag, ".dout"}, 32'(bus.dout), 32'(dout));
        chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(dv));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(emp));
        chk({tag, ".full"}, 32'(bus.full), 32'(full));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(udf));
    endtask

    // Drive on the falling edge, let one rising edge act, sample 1 time unit later.
    task automatic step(input logic c, input logic pu, input logic po, input logic [7:0] d);
        @(negedge clk);
        bus.clear = c;
        bus.push  = pu;
        bus.pop   = po;
        bus.din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.din   = 8'h00;

        //          clr   push  pop   din    cnt    top    dout   dv    emp   full  af    ovf   udf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h33, 5'd3, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h01, 5'd1, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h02, 5'd2, 8'h02, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h7F, 5'd2, 8'h7F, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h5C, 5'd0, 8'h00, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h44, 5'd0, 8'h00, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        #12;
        chk_all("reset", 5'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].clear, vecs[i].push, vecs[i].pop, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].top, vecs[i].dout, vecs[i].dv,
                    vecs[i].empty, vecs[i].full, vecs[i].af, vecs[i].ovf, vecs[i].udf);
        end

        // Fill to DEPTH, watching almost_full and full thresholds.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i));
            chk($sformatf("fill%0d.count", i), 32'(bus.count), 32'(i + 1));
            chk($sformatf("fill%0d.top", i), 32'(bus.top), 32'(8'h10 + 8'(i)));
            chk($sformatf("fill%0d.almost_full", i), 32'(bus.almost_full), 32'((i + 1) >= 14));
            chk($sformatf("fill%0d.full", i), 32'(bus.full), 32'((i + 1) == 16));
        end
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk_all("full_replace", 5'd16, 8'h77, 8'h1F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk_all("overflow", 5'd16, 8'h77, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk_all("pop_after_ovf", 5'd15, 8'h1E, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a clock phase.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
        end
        chk("pre_rst.count", 32'(bus.count), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async_rst", 5'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.push = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h99);
        chk_all("post_rst_push", 5'd1, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk_all("post_rst_pop", 5'd0, 8'h00, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
